// File: rtl/zion_rvi_bits_op_issue_pkg.sv
// Shared RVI bit-op definitions: opcode and funct3 constants and the
// per-bundle select/destination fields carried alongside the operands.
package zion_rvi_bits_op_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;

  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_XOR = 3'b100;

  // Operand-independent half of the bits-op bundle; the top pairs it with
  // s1/s2 at the configured datapath width.
  typedef struct packed {
    logic       and_en;
    logic       or_en;
    logic       xor_en;
    logic [4:0] rd;
  } bits_sel_t;

endpackage

// File: rtl/zion_rvi_bits_dec.sv
// Combinational decode of an RVI AND/OR/XOR(I) instruction into operands,
// one-hot operation select and destination index.
module zion_rvi_bits_dec
  import zion_rvi_bits_op_issue_pkg::*;
#(
  parameter int CPU_WIDTH = 32
) (
  input  logic [31:0]          instr,
  input  logic [CPU_WIDTH-1:0] rs1,
  input  logic [CPU_WIDTH-1:0] rs2,
  output logic [CPU_WIDTH-1:0] s1,
  output logic [CPU_WIDTH-1:0] s2,
  output bits_sel_t            sel,
  output logic                 unsup
);

  logic r_type;
  logic i_type;
  logic f3_ok;

  always_comb begin
    r_type = 1'b0;
    i_type = 1'b0;
    casez (instr)
      {F7_BASE, 18'b??????????????????, OPC_OP}: r_type = 1'b1;
      {25'b?????????????????????????, OPC_OP_IMM}: i_type = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    sel        = '0;
    sel.rd     = instr[11:7];
    f3_ok      = 1'b1;
    case (instr[14:12])
      F3_AND:  sel.and_en = 1'b1;
      F3_OR:   sel.or_en  = 1'b1;
      F3_XOR:  sel.xor_en = 1'b1;
      default: f3_ok      = 1'b0;
    endcase
  end

  assign unsup = !((r_type || i_type) && f3_ok);
  assign s1    = rs1;
  assign s2    = r_type ? rs2 : {{(CPU_WIDTH-12){instr[31]}}, instr[31:20]};

endmodule

// File: rtl/zion_rvi_bits_op_issue.sv
// Issue stage for RVI bitwise ops: decodes the register-read packet and
// queues operand bundles in a small FIFO toward the bits-op execute unit.
module zion_rvi_bits_op_issue
  import zion_rvi_bits_op_issue_pkg::*;
#(
  parameter int RV64  = 0,
  parameter int DEPTH = 2,
  localparam int CPU_WIDTH = 32 * (RV64 + 1),
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iVld,
  output logic                 oRdy,
  input  logic [31:0]          iInstr,
  input  logic [CPU_WIDTH-1:0] iRs1Val,
  input  logic [CPU_WIDTH-1:0] iRs2Val,
  input  logic                 iFlush,
  output logic                 oUnsup,
  output logic                 oVld,
  input  logic                 iRdy,
  output logic [CPU_WIDTH-1:0] oS1,
  output logic [CPU_WIDTH-1:0] oS2,
  output logic                 oAndEn,
  output logic                 oOrEn,
  output logic                 oXorEn,
  output logic [4:0]           oRd,
  output logic [AW:0]          oCnt
);

  typedef struct packed {
    logic [CPU_WIDTH-1:0] s1;
    logic [CPU_WIDTH-1:0] s2;
    bits_sel_t            sel;
  } bundle_t;

  bundle_t        dec_bundle;
  bundle_t        head;
  bundle_t        mem [DEPTH];
  logic           dec_unsup;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    cnt;
  logic           unsup_q;
  logic           accept;
  logic           push;
  logic           pop;

  zion_rvi_bits_dec #(.CPU_WIDTH(CPU_WIDTH)) u_dec (
    .instr (iInstr),
    .rs1   (iRs1Val),
    .rs2   (iRs2Val),
    .s1    (dec_bundle.s1),
    .s2    (dec_bundle.s2),
    .sel   (dec_bundle.sel),
    .unsup (dec_unsup)
  );

  // Handshake: a beat moves on either side only when valid and ready are both
  // high at the clock edge; oRdy depends only on registered occupancy, so a
  // full queue does not accept even while the consumer is popping.
  assign oRdy   = (cnt < (AW+1)'(DEPTH));
  assign oVld   = (cnt != '0);
  assign accept = iVld && oRdy;
  assign push   = accept && !dec_unsup;
  assign pop    = oVld && iRdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      unsup_q <= 1'b0;
    end else if (iFlush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      unsup_q <= 1'b0;
    end else begin
      unsup_q <= accept && dec_unsup;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec_bundle;
  end

  assign head   = oVld ? mem[rd_ptr] : '0;
  assign oS1    = head.s1;
  assign oS2    = head.s2;
  assign oAndEn = head.sel.and_en;
  assign oOrEn  = head.sel.or_en;
  assign oXorEn = head.sel.xor_en;
  assign oRd    = head.sel.rd;
  assign oCnt   = cnt;
  assign oUnsup = unsup_q;

endmodule

// File: tb/tb_zion_rvi_bits_op_issue.sv
// Bench for zion_rvi_bits_op_issue: directed cases then random traffic,
// checked cycle by cycle against a queue-based model of the issue FIFO.
module tb_zion_rvi_bits_op_issue;

  localparam int RV64  = 0;
  localparam int DEPTH = 2;
  localparam int CW    = 32 * (RV64 + 1);
  localparam int NW    = $clog2(DEPTH) + 1;
  localparam int W     = 2 * CW + 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iVld = 1'b0;
  logic          oRdy;
  logic [31:0]   iInstr = '0;
  logic [CW-1:0] iRs1Val = '0;
  logic [CW-1:0] iRs2Val = '0;
  logic          iFlush = 1'b0;
  logic          oUnsup;
  logic          oVld;
  logic          iRdy = 1'b0;
  logic [CW-1:0] oS1;
  logic [CW-1:0] oS2;
  logic          oAndEn;
  logic          oOrEn;
  logic          oXorEn;
  logic [4:0]    oRd;
  logic [NW-1:0] oCnt;

  zion_rvi_bits_op_issue #(.RV64(RV64), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .iVld(iVld), .oRdy(oRdy), .iInstr(iInstr),
    .iRs1Val(iRs1Val), .iRs2Val(iRs2Val), .iFlush(iFlush), .oUnsup(oUnsup),
    .oVld(oVld), .iRdy(iRdy), .oS1(oS1), .oS2(oS2), .oAndEn(oAndEn),
    .oOrEn(oOrEn), .oXorEn(oXorEn), .oRd(oRd), .oCnt(oCnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_unsup = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the ISA fields.
  function automatic logic [W-1:0] ref_decode(input logic [31:0] ins, input logic [CW-1:0] r1,
                                                input logic [CW-1:0] r2, output logic ok);
    logic [6:0]    opc;
    logic [2:0]    f3;
    logic          is_r, is_i;
    logic [CW-1:0] s2;
    logic          a, o, x;
    opc  = ins[6:0];
    f3   = ins[14:12];
    is_r = (opc == 7'h33) && (ins[31:25] == 7'h00);
    is_i = (opc == 7'h13);
    a    = (f3 == 3'd7);
    o    = (f3 == 3'd6);
    x    = (f3 == 3'd4);
    ok   = (is_r || is_i) && (a || o || x);
    s2   = is_r ? r2 : CW'($signed(ins[31:20]));
    return {r1, s2, a, o, x, ins[11:7]};
  endfunction

  function automatic logic [31:0] mk_r(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] f7);
    return {f7, 5'($urandom), 5'($urandom), f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'($urandom), f3, rd, 7'h13};
  endfunction

  function automatic logic [CW-1:0] rnd_val();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[CW-1:0];
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [2:0] ops [3];
    logic [2:0] f3;
    ops[0] = 3'd7; ops[1] = 3'd6; ops[2] = 3'd4;
    f3 = ops[$urandom_range(0, 2)];
    case ($urandom_range(0, 6))
      0, 1:    return mk_r(f3, 5'($urandom), 7'h00);
      2, 3:    return mk_i(12'($urandom), f3, 5'($urandom));
      4:       return mk_r(3'($urandom), 5'($urandom), 7'($urandom));
      5:       return mk_i(12'($urandom), 3'($urandom), 5'($urandom));
      default: return {25'($urandom), 7'b0000011};
    endcase
  endfunction

  task automatic check_outputs();
    logic [W-1:0] e;
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("ovld",   oVld,   exp_q.size() != 0);
    check("ocnt",   oCnt,   exp_q.size());
    check("ounsup", oUnsup, exp_unsup);
    check("os1",    oS1,    e[W-1 -: CW]);
    check("os2",    oS2,    e[CW+7 -: CW]);
    check("oand",   oAndEn, e[7]);
    check("oor",    oOrEn,  e[6]);
    check("oxor",   oXorEn, e[5]);
    check("ord",    oRd,    e[4:0]);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive one cycle, advance the model across the posedge,
  // and compare at the following negedge.
  task automatic step(input logic vld, input logic [31:0] ins, input logic [CW-1:0] r1,
                      input logic [CW-1:0] r2, input logic rdy, input logic fl);
    logic         ok;
    logic [W-1:0] b;
    int           sz;
    bit           acc, pop;
    iVld = vld; iInstr = ins; iRs1Val = r1; iRs2Val = r2; iRdy = rdy; iFlush = fl;
    b  = ref_decode(ins, r1, r2, ok);
    sz = exp_q.size();
    #1;
    check("ordy", oRdy, sz < DEPTH);
    acc = vld && (sz < DEPTH);
    pop = (sz != 0) && rdy;
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (acc && ok) exp_q.push_back(b);
    end
    exp_unsup = acc && !ok && !fl;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, '0, '0, rdy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] and_i, or_i;
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    check("ordy_rst", oRdy, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // AND, register form
    and_i = mk_r(3'd7, 5'd9, 7'h00);
    step(1'b1, and_i, CW'(32'hF0F0_F0F0), CW'(32'h0FF0_0FF0), 1'b1, 1'b0);
    idle(1'b1);
    // XORI with all-ones immediate
    step(1'b1, mk_i(12'hFFF, 3'd4, 5'd3), CW'(32'h1234_5678), rnd_val(), 1'b1, 1'b0);
    check("xori_s2", oS2, {CW{1'b1}});
    idle(1'b1);
    // ADD is unsupported; SUB-style funct7 on AND also unsupported
    step(1'b1, mk_r(3'd0, 5'd1, 7'h00), rnd_val(), rnd_val(), 1'b1, 1'b0);
    step(1'b1, mk_r(3'd7, 5'd1, 7'h20), rnd_val(), rnd_val(), 1'b1, 1'b0);
    idle(1'b1);

    // Fill with iRdy low, third offer refused, then drain
    or_i = mk_r(3'd6, 5'd4, 7'h00);
    step(1'b1, or_i, rnd_val(), rnd_val(), 1'b0, 1'b0);
    step(1'b1, mk_i(12'h7F0, 3'd6, 5'd5), rnd_val(), rnd_val(), 1'b0, 1'b0);
    step(1'b1, or_i, rnd_val(), rnd_val(), 1'b0, 1'b0);
    // Full with pop and offered input: no push this cycle
    step(1'b1, and_i, rnd_val(), rnd_val(), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Steady stream of 10 ops
    for (int i = 0; i < 10; i++) step(1'b1, mk_r(3'd4, 5'(i), 7'h00), rnd_val(), rnd_val(), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Flush: full plus offered push; one queued plus accepted push; unsupported during flush
    step(1'b1, or_i, rnd_val(), rnd_val(), 1'b0, 1'b0);
    step(1'b1, or_i, rnd_val(), rnd_val(), 1'b0, 1'b0);
    step(1'b1, and_i, rnd_val(), rnd_val(), 1'b1, 1'b1);
    step(1'b1, or_i, rnd_val(), rnd_val(), 1'b0, 1'b0);
    step(1'b1, and_i, rnd_val(), rnd_val(), 1'b0, 1'b1);
    step(1'b1, mk_r(3'd0, 5'd2, 7'h00), rnd_val(), rnd_val(), 1'b0, 1'b1);
    step(1'b1, and_i, rnd_val(), rnd_val(), 1'b1, 1'b0);
    idle(1'b1);

    // Asynchronous reset mid-stream
    step(1'b1, or_i, rnd_val(), rnd_val(), 1'b0, 1'b0);
    step(1'b1, mk_r(3'd5, 5'd2, 7'h00), rnd_val(), rnd_val(), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_ovld", oVld, 1'b0);
    check("rst_ocnt", oCnt, '0);
    check("rst_unsup", oUnsup, 1'b0);
    exp_q.delete();
    exp_unsup = 1'b0;
    iVld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, and_i, CW'(32'hDEAD_BEEF), rnd_val(), 1'b1, 1'b0);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, rnd_instr(), rnd_val(), rnd_val(),
           $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
